// File: rtl/dcount_scan_pkg.sv
// Shared definitions for the multiplexed display scanner and its helpers.
// Holds the scan phase encoding, the segment reset pattern and a clog2 helper.
// Pure declarations; no logic, no latency, no flow control.
package dcount_scan_pkg;

  // Scan phase within one digit slot
  typedef enum logic [1:0] {
    S_BLANK = 2'd0,
    S_ON    = 2'd1,
    S_OFF   = 2'd2
  } scan_state_t;

  // Segment bus idle pattern (all segments off on common-anode boards); sliced to SEGW
  localparam logic [63:0] SEG_RESET = '1;

  // Ceiling log2 usable in parameter and port width expressions; clog2(1) = 0
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< r) < v) r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/dscan_sel_dec.sv
// Index to one-hot digit-select decoder with selectable output polarity.
// Purely combinational, zero latency.
// No flow control; en=0 drives every select to its inactive level.
module dscan_sel_dec #(
  parameter int N          = 4,
  parameter int IW         = 2,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic [IW-1:0] idx,
  input  logic          en,
  output logic [N-1:0]  sel
);

  logic [N-1:0] hot;

  // Active-high one-hot of idx, gated by en
  always_comb begin
    hot = '0;
    for (int i = 0; i < N; i++) begin
      if (en && (idx == IW'(i))) hot[i] = 1'b1;
    end
  end

  // Apply board polarity
  assign sel = ACTIVE_LOW ? ~hot : hot;

endmodule

// File: rtl/dcount_scan.sv
// Multiplexed display scanner: blank + dwell per digit, duty control, digit mask, frame pulse.
// All outputs registered; segment/brightness sampled once per slot at the end of blanking.
// ENABLE is the scan tick; with ENABLE low every register holds except FRAME, which self-clears.
module dcount_scan
  import dcount_scan_pkg::*;
#(
  parameter int NDIG          = 4,
  parameter int SEGW          = 8,
  parameter int DWELL         = 4,
  parameter int BLANK         = 1,
  parameter int SA_ACTIVE_LOW = 1,
  parameter int BW            = clog2(DWELL + 1)
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     ENABLE,
  input  logic [NDIG*SEGW-1:0]     SEG_IN,
  input  logic [NDIG-1:0]          DIG_EN,
  input  logic [BW-1:0]            BRIGHT,
  output logic [NDIG-1:0]          SA,
  output logic [SEGW-1:0]          L,
  output logic [clog2(NDIG)-1:0]   DIGIT_IDX,
  output logic                     FRAME
);

  localparam int IW   = clog2(NDIG);
  localparam int CMAX = (BLANK > DWELL) ? BLANK : DWELL;
  localparam int CW   = clog2(CMAX + 1);
  localparam logic [NDIG-1:0] SA_IDLE = (SA_ACTIVE_LOW != 0) ? {NDIG{1'b1}} : {NDIG{1'b0}};

  scan_state_t     state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [IW-1:0]   idx, idx_n;
  logic [BW-1:0]   bright_r, bright_n;
  logic [NDIG-1:0] sa_r, sa_n;
  logic [SEGW-1:0] l_r, l_n;
  logic            frame_r, frame_n;

  logic [NDIG-1:0] sel_lit;
  logic [BW-1:0]   bright_sat;
  logic [SEGW-1:0] seg_cur;
  logic            last_idx;

  // Select pattern for the digit whose slot is current
  dscan_sel_dec #(
    .N          (NDIG),
    .IW         (IW),
    .ACTIVE_LOW (SA_ACTIVE_LOW != 0)
  ) u_sel_dec (
    .idx (idx),
    .en  (1'b1),
    .sel (sel_lit)
  );

  assign bright_sat = (BRIGHT > BW'(DWELL)) ? BW'(DWELL) : BRIGHT;
  assign seg_cur    = SEG_IN[idx*SEGW +: SEGW];
  assign last_idx   = (idx == IW'(NDIG - 1));

  // Next-state and next-output logic; everything holds unless an ENABLE tick moves it
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    idx_n    = idx;
    bright_n = bright_r;
    sa_n     = sa_r;
    l_n      = l_r;
    frame_n  = 1'b0;
    if (ENABLE) begin
      case (state)
        S_BLANK: begin
          sa_n = SA_IDLE;
          if (cnt == CW'(BLANK - 1)) begin
            // Slot start: freeze duty and segments for the whole dwell window
            bright_n = bright_sat;
            cnt_n    = '0;
            if (DIG_EN[idx] && (bright_sat != '0)) begin
              state_n = S_ON;
              sa_n    = sel_lit;
              l_n     = seg_cur;
            end else begin
              state_n = S_OFF;
            end
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
        S_ON, S_OFF: begin
          if (cnt == CW'(DWELL - 1)) begin
            sa_n    = SA_IDLE;
            state_n = S_BLANK;
            cnt_n   = '0;
            idx_n   = last_idx ? '0 : idx + IW'(1);
            frame_n = last_idx;
          end else begin
            if (state == S_OFF) begin
              sa_n = SA_IDLE;
            end else if (({1'b0, cnt} + (CW+1)'(1)) == (CW+1)'(bright_r)) begin
              // Duty exhausted: go dark for the rest of the dwell window
              state_n = S_OFF;
              sa_n    = SA_IDLE;
            end
            cnt_n = cnt + CW'(1);
          end
        end
        default: begin
          state_n = S_BLANK;
          cnt_n   = '0;
          sa_n    = SA_IDLE;
        end
      endcase
    end
  end

  // State and output registers with synchronous reset taking priority over ENABLE
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= S_BLANK;
      cnt      <= '0;
      idx      <= '0;
      bright_r <= '0;
      sa_r     <= SA_IDLE;
      l_r      <= SEG_RESET[SEGW-1:0];
      frame_r  <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      idx      <= idx_n;
      bright_r <= bright_n;
      sa_r     <= sa_n;
      l_r      <= l_n;
      frame_r  <= frame_n;
    end
  end

  assign SA        = sa_r;
  assign L         = l_r;
  assign DIGIT_IDX = idx;
  assign FRAME     = frame_r;

endmodule

// File: tb/tb_dcount_scan.sv
// Randomized scoreboard bench for dcount_scan with default parameters.
// Model works from tick position in the frame; expectations are queued per clock.
// A negedge monitor pops one expectation per clock and compares all outputs.
module tb_dcount_scan;

  localparam int NDIG  = 4;
  localparam int SEGW  = 8;
  localparam int DWELL = 4;
  localparam int BLANK = 1;
  localparam int BW    = 3;
  localparam int SL    = BLANK + DWELL;

  logic                 CLK;
  logic                 RST;
  logic                 ENABLE;
  logic [NDIG*SEGW-1:0] SEG_IN;
  logic [NDIG-1:0]      DIG_EN;
  logic [BW-1:0]        BRIGHT;
  logic [NDIG-1:0]      SA;
  logic [SEGW-1:0]      L;
  logic [1:0]           DIGIT_IDX;
  logic                 FRAME;

  typedef struct packed {
    logic [3:0] sa;
    logic [7:0] l;
    logic [1:0] idx;
    logic       fr;
  } exp_t;

  exp_t exp_q[$];
  int   tests  = 0;
  int   errors = 0;
  int   pushed = 0;
  int   popped = 0;

  // Reference model state: ENABLE ticks since reset plus values captured at slot start
  int         k      = 0;
  int         b_snap = 0;
  bit         on_snap = 0;
  logic [7:0] l_mod  = 8'hFF;

  dcount_scan dut (
    .CLK       (CLK),
    .RST       (RST),
    .ENABLE    (ENABLE),
    .SEG_IN    (SEG_IN),
    .DIG_EN    (DIG_EN),
    .BRIGHT    (BRIGHT),
    .SA        (SA),
    .L         (L),
    .DIGIT_IDX (DIGIT_IDX),
    .FRAME     (FRAME)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Advance the model by one clock edge using the inputs present at that edge
  task automatic model_edge();
    exp_t e;
    int   r, slot, d, b;
    bit   fr;
    fr = 1'b0;
    if (RST) begin
      k = 0; l_mod = 8'hFF; on_snap = 0; b_snap = 0;
    end else if (ENABLE) begin
      k = k + 1;
      r = k % SL;
      slot = (k / SL) % NDIG;
      if (r == BLANK) begin
        b = (int'(BRIGHT) > DWELL) ? DWELL : int'(BRIGHT);
        b_snap = b;
        on_snap = DIG_EN[slot] && (b > 0);
        if (on_snap) l_mod = SEG_IN[slot*SEGW +: SEGW];
      end
      fr = (k % (SL * NDIG)) == 0;
    end
    r = k % SL;
    slot = (k / SL) % NDIG;
    d = r - BLANK;
    e.sa = 4'hF;
    if (r >= BLANK && on_snap && d < b_snap) e.sa[slot] = 1'b0;
    e.l   = l_mod;
    e.idx = 2'(slot);
    e.fr  = fr;
    exp_q.push_back(e);
    pushed++;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      model_edge();
      #1;
    end
  endtask

  task automatic rand_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      ENABLE = ($urandom_range(0, 3) != 0);
      RST    = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 15) == 0) BRIGHT = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 31) == 0) DIG_EN = 4'($urandom);
      if ($urandom_range(0, 3) == 0)  SEG_IN[$urandom_range(0, 3)*SEGW +: SEGW] = 8'($urandom);
      @(posedge CLK);
      model_edge();
      #1;
    end
    RST = 1'b0;
  endtask

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
    end
  endtask

  // Monitor: every clock presents a registered output set; compare against the queue head
  always @(negedge CLK) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      popped++;
      check("sa", int'(SA), int'(e.sa));
      check("l", int'(L), int'(e.l));
      check("digit_idx", int'(DIGIT_IDX), int'(e.idx));
      check("frame", int'(FRAME), int'(e.fr));
    end
  end

  initial begin
    RST = 1'b1; ENABLE = 1'b1; BRIGHT = 3'd4; DIG_EN = 4'b1111;
    SEG_IN = {8'h44, 8'h33, 8'h22, 8'h11};
    #1;
    // Reset held with ENABLE high
    cycles(3);
    RST = 1'b0;
    // Full brightness scan, three frames
    cycles(60);
    // Dimming: one lit tick per slot, then fully dark
    BRIGHT = 3'd1; cycles(45);
    BRIGHT = 3'd0; cycles(45);
    // Saturating brightness above DWELL
    BRIGHT = 3'd7; cycles(25);
    // Digit mask: odd digits never lit, L holds
    BRIGHT = 3'd4; DIG_EN = 4'b0101; cycles(45);
    DIG_EN = 4'b1111;
    // Tick gating: ENABLE one clock in three
    for (int i = 0; i < 70; i++) begin
      ENABLE = (i % 3 == 0); cycles(1);
    end
    ENABLE = 1'b1;
    // Snapshot: change digit 0 mid-dwell after a fresh start
    RST = 1'b1; cycles(1); RST = 1'b0;
    cycles(2);
    SEG_IN[7:0] = 8'hAA;
    cycles(25);
    // Reset during digit 2 lit window
    RST = 1'b1; cycles(1); RST = 1'b0;
    cycles(12);
    RST = 1'b1; cycles(1); RST = 1'b0;
    cycles(10);
    // Randomized traffic
    rand_cycles(1500);
    @(negedge CLK);
    #1;
    check("scoreboard_drain", popped, pushed);
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
